uart_sram_bridge: RTL and testbench
===================================

# uart_sram_bridge

Parametrised UART-to-SRAM command bridge, successor to the fixed 32-bit/16-word SRAM controller. It sits between the UART receiver/transmitter pair and a single-port SRAM macro. It parses a byte-serial command stream, performs single or burst reads/writes of DATA_W-bit words with auto-incrementing address, and returns read data and status bytes over UART. It also aborts stalled commands on an inter-byte timeout.

## Interface
Parameters:
- DATA_W, 32, SRAM word width; multiple of 8, range 8..64; BYTES = DATA_W/8
- ADDR_W, 4, SRAM address width, range 1..8
- TIMEOUT_CYC, 100000, idle cycles allowed between bytes inside a command; minimum 2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts a byte this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- sram_csb_n  out  1  SRAM chip select, active low
- sram_web_n  out  1  SRAM write enable, active low
- sram_addr  out  ADDR_W  SRAM address
- sram_din  out  DATA_W  SRAM write data
- sram_dout  in  DATA_W  SRAM read data
- busy  out  1  high whenever the FSM is not in IDLE
- err  out  1  one-cycle pulse on timeout or bad opcode

## Operation
- A byte transfers when valid && ready are high in the same cycle, on both RX and TX.
- Command frame: CMD, ADDR, LEN, then payload (writes only).
  - CMD[7:6]: 00 write, 01 read, 10 ping, 11 invalid.
  - ADDR[ADDR_W-1:0] is the start address; upper bits are ignored.
  - LEN is the word count minus 1 (1..256 words).
- Ping: replies 0x5A immediately after CMD; no ADDR or LEN bytes follow.
- Invalid opcode: pulse err, reply 0xEE, return to IDLE.
- Write: collect BYTES bytes little-endian (first byte goes to [7:0]), then commit one word. Repeat for LEN+1 words, then reply 0xA5.
- Read: for each word, issue SRAM read, capture data, send BYTES bytes LSB first. No trailing status byte.
- Address increments by 1 after each word, modulo 2^ADDR_W (wraps 2^ADDR_W-1 -> 0).
- FSM states: IDLE, GET_ADDR, GET_LEN, WR_COLLECT, WR_COMMIT, RD_ISSUE, RD_WAIT, RD_SEND, SEND_RESP.
  - IDLE -(CMD)-> GET_ADDR (write/read) or SEND_RESP (ping/invalid)
  - GET_ADDR -> GET_LEN
  - GET_LEN -> WR_COLLECT (write) or RD_ISSUE (read)
  - WR_COLLECT -(BYTES-th byte)-> WR_COMMIT
  - WR_COMMIT -> WR_COLLECT, or SEND_RESP after the last word
  - RD_ISSUE -> RD_WAIT -> RD_SEND
  - RD_SEND -(last byte)-> RD_ISSUE, or IDLE after the last word
  - SEND_RESP -(tx handshake)-> IDLE
- rx_ready is high only in IDLE, GET_ADDR, GET_LEN and WR_COLLECT.
- RX bytes arriving in other states are held off by rx_ready = 0 and are never dropped by the bridge.
- Timeout: in GET_ADDR, GET_LEN or WR_COLLECT, a counter resets on every accepted byte. When it reaches TIMEOUT_CYC: pulse err, discard the partial word and remaining burst, go to IDLE with no reply. Words already committed stay written.
- The timeout does not run while waiting on tx_ready.

## Timing
- Reset values: rx_ready 0 (1 from the first cycle after reset), tx_valid 0, tx_data 0x00, sram_csb_n 1, sram_web_n 1, sram_addr 0, sram_din 0, busy 0, err 0.
- All outputs are registered.
- WR_COMMIT lasts exactly one cycle: csb_n = 0, web_n = 0, addr and din stable.
- RD_ISSUE lasts one cycle with csb_n = 0, web_n = 1. sram_dout is captured at the end of RD_WAIT (one-cycle macro latency).
- csb_n is 1 in every other state.
- The first read byte is presented on tx_valid 3 cycles after the LEN byte handshake.
- tx_valid and tx_data hold stable until tx_ready. The next byte is presented in the cycle after a handshake (one idle cycle between bytes).
- Reset asserted mid-command: next cycle the bridge is in IDLE with all outputs at reset values. Any in-flight SRAM access is cancelled by csb_n = 1.

## Structure
- Package uart_sram_pkg holds:
  - opcode constants OP_WR, OP_RD, OP_PING, OP_BAD
  - response bytes RSP_ACK 0xA5, RSP_PING 0x5A, RSP_ERR 0xEE
  - FSM state enum
- Sub-module word_packer (parametrised by DATA_W):
  - byte-to-word shift-in for writes
  - word-to-byte shift-out for reads
  - internal byte index counter with a last-byte flag
- Top-level FSM, address counter, word counter and timeout counter live in uart_sram_bridge.

## Test plan
- DATA_W=32, ADDR_W=4: send 00 03 00 EF BE AD DE -> one SRAM write at addr 3 with din 0xDEADBEEF, then tx 0xA5.
- Read back with 40 03 00 -> tx EF BE AD DE in that order. Measure 3 cycles from the LEN handshake to the first tx_valid.
- Burst wrap: write 3 words starting at addr 0xE -> commits at 0xE, 0xF, 0x0. A 3-word read at 0xE returns the same data.
- Ping 80 and invalid C0 -> tx 0x5A; err pulse plus tx 0xEE; busy low afterwards.
- Timeout, TIMEOUT_CYC=16: send 00 05 01 plus 2 data bytes, then stall -> err pulses 16 cycles after the last byte, no SRAM write occurs, and no reply is sent.
- Hold tx_ready low for 50 cycles mid-read -> tx_data stable throughout, rx_ready 0, no timeout. Assert reset mid-burst -> all outputs return to reset values.

Source files
------------

// File: rtl/uart_sram_pkg.sv
// Shared opcodes, response bytes and FSM state encoding for the UART-to-SRAM bridge.
package uart_sram_pkg;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_PING = 2'b10;
  localparam logic [1:0] OP_BAD  = 2'b11;

  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_PING = 8'h5A;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    WR_COLLECT,
    WR_COMMIT,
    RD_ISSUE,
    RD_WAIT,
    RD_SEND,
    SEND_RESP
  } state_e;

  // States in which the bridge consumes command/payload bytes.
  function automatic logic accepts_rx(state_e s);
    return (s == IDLE) || (s == GET_ADDR) || (s == GET_LEN) || (s == WR_COLLECT);
  endfunction

  // States in which a stalled sender is aborted by the inter-byte timeout.
  function automatic logic has_timeout(state_e s);
    return (s == GET_ADDR) || (s == GET_LEN) || (s == WR_COLLECT);
  endfunction

endpackage

// File: rtl/word_packer.sv
// Byte<->word converter: little-endian shift-in for writes, LSB-first shift-out for reads.
module word_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_in,
  input  logic              load,
  input  logic              shift_out,
  input  logic [7:0]        in_byte,
  input  logic [DATA_W-1:0] load_word,
  output logic [7:0]        out_byte,
  output logic              last,
  output logic [DATA_W-1:0] word_next
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // New bytes enter at the top so that after BYTES shifts the first byte sits in [7:0].
  if (DATA_W == 8) begin : g_single
    assign word_next = in_byte;
  end else begin : g_multi
    assign word_next = {in_byte, shreg_q[DATA_W-1:8]};
  end

  assign out_byte = shreg_q[7:0];
  assign last     = (idx_q == IDX_W'(BYTES - 1));

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (load) begin
      shreg_d = load_word;
      idx_d   = '0;
    end else if (shift_in || shift_out) begin
      shreg_d = shift_in ? word_next : (shreg_q >> 8);
      idx_d   = last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments only, so every flop samples the
  // pre-edge value of every other flop regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/uart_sram_bridge.sv
// Command parser bridging a UART byte stream to a single-port SRAM, with burst
// auto-increment and an inter-byte timeout.
module uart_sram_bridge
  import uart_sram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              sram_csb_n,
  output logic              sram_web_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              busy,
  output logic              err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        words_q, words_d;
  logic              is_wr_q, is_wr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              csb_n_q, csb_n_d;
  logic              web_n_q, web_n_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_din_q, sram_din_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              pk_clear, pk_shift_in, pk_load, pk_shift_out;
  logic [7:0]        pk_out_byte;
  logic              pk_last;
  logic [DATA_W-1:0] pk_word;

  logic              rx_fire, tx_fire, tmo_hit, last_word;

  word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .shift_in  (pk_shift_in),
    .load      (pk_load),
    .shift_out (pk_shift_out),
    .in_byte   (rx_data),
    .load_word (sram_dout),
    .out_byte  (pk_out_byte),
    .last      (pk_last),
    .word_next (pk_word)
  );

  assign rx_fire   = rx_valid && rx_ready_q;
  assign tx_fire   = tx_valid_q && tx_ready;
  assign last_word = (words_q == 8'd0);
  // Counter holds the number of cycles since the last accepted byte.
  assign tmo_hit   = has_timeout(state_q) && !rx_fire &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_d      = words_q;
    is_wr_d      = is_wr_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    csb_n_d      = 1'b1;
    web_n_d      = 1'b1;
    sram_addr_d  = sram_addr_q;
    sram_din_d   = sram_din_q;
    err_d        = 1'b0;
    pk_clear     = 1'b0;
    pk_shift_in  = 1'b0;
    pk_load      = 1'b0;
    pk_shift_out = 1'b0;

    unique case (state_q)
      IDLE: begin
        pk_clear = 1'b1;
        if (rx_fire) begin
          unique case (rx_data[7:6])
            OP_WR: begin
              state_d = GET_ADDR;
              is_wr_d = 1'b1;
            end
            OP_RD: begin
              state_d = GET_ADDR;
              is_wr_d = 1'b0;
            end
            OP_PING: begin
              state_d    = SEND_RESP;
              tx_valid_d = 1'b1;
              tx_data_d  = RSP_PING;
            end
            OP_BAD: begin
              state_d    = SEND_RESP;
              tx_valid_d = 1'b1;
              tx_data_d  = RSP_ERR;
              err_d      = 1'b1;
            end
          endcase
        end
      end
      GET_ADDR: begin
        if (rx_fire) begin
          addr_d  = rx_data[ADDR_W-1:0];
          state_d = GET_LEN;
        end
      end
      GET_LEN: begin
        if (rx_fire) begin
          words_d = rx_data;
          if (is_wr_q) begin
            state_d = WR_COLLECT;
          end else begin
            state_d     = RD_ISSUE;
            csb_n_d     = 1'b0;
            sram_addr_d = addr_q;
          end
        end
      end
      WR_COLLECT: begin
        if (rx_fire) begin
          pk_shift_in = 1'b1;
          if (pk_last) begin
            state_d     = WR_COMMIT;
            csb_n_d     = 1'b0;
            web_n_d     = 1'b0;
            sram_addr_d = addr_q;
            sram_din_d  = pk_word;
          end
        end
      end
      WR_COMMIT: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_word) begin
          state_d    = SEND_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_ACK;
        end else begin
          words_d = words_q - 8'd1;
          state_d = WR_COLLECT;
        end
      end
      RD_ISSUE: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        pk_load    = 1'b1;
        state_d    = RD_SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = sram_dout[7:0];
      end
      RD_SEND: begin
        if (tx_fire) begin
          tx_valid_d   = 1'b0;
          pk_shift_out = 1'b1;
          if (pk_last) begin
            if (last_word) begin
              state_d = IDLE;
            end else begin
              words_d     = words_q - 8'd1;
              state_d     = RD_ISSUE;
              csb_n_d     = 1'b0;
              sram_addr_d = addr_q;
            end
          end
        end else if (!tx_valid_q) begin
          // One idle cycle after each handshake, then present the next byte.
          tx_valid_d = 1'b1;
          tx_data_d  = pk_out_byte;
        end
      end
      SEND_RESP: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stall drops the partial word and the rest of the burst without a reply.
    if (tmo_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end

    if (rx_fire || !has_timeout(state_q)) tmo_d = TMO_W'(1);
    else                                  tmo_d = tmo_q + TMO_W'(1);

    rx_ready_d = accepts_rx(state_d);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      words_q     <= '0;
      is_wr_q     <= 1'b0;
      tmo_q       <= TMO_W'(1);
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      csb_n_q     <= 1'b1;
      web_n_q     <= 1'b1;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      is_wr_q     <= is_wr_d;
      tmo_q       <= tmo_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      csb_n_q     <= csb_n_d;
      web_n_q     <= web_n_d;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign sram_csb_n = csb_n_q;
  assign sram_web_n = web_n_q;
  assign sram_addr  = sram_addr_q;
  assign sram_din   = sram_din_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_sram_bridge.sv
// Randomised self-checking bench for uart_sram_bridge against a command-level memory model.
module tb_uart_sram_bridge;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int TMO    = 16;
  localparam int BYTES  = DATA_W / 8;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              sram_csb_n, sram_web_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout = '0;
  logic              busy, err;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int rx_gap_max = 0;
  int tx_gap_max = 0;

  logic [DATA_W-1:0]        sram    [WORDS];
  logic [DATA_W-1:0]        ref_mem [WORDS];
  logic [DATA_W-1:0]        wdata   [8];
  logic [ADDR_W+DATA_W-1:0] wr_log  [$];

  uart_sram_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .sram_csb_n (sram_csb_n),
    .sram_web_n (sram_web_n),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Single-port SRAM macro with one-cycle read latency.
  always @(posedge clk) begin
    if (!sram_csb_n) begin
      if (!sram_web_n) sram[sram_addr] <= sram_din;
      else             sram_dout <= sram[sram_addr];
    end
  end

  always @(posedge clk) begin
    if (!reset && !sram_csb_n && !sram_web_n) wr_log.push_back({sram_addr, sram_din});
  end

  always @(negedge clk) if (err) err_pulses++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, rx_gap_max)) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_accept_timeout", 0, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_valid) begin
      check("tx_wait_timeout", 0, 1);
      b = 8'h00;
      return;
    end
    repeat ($urandom_range(0, tx_gap_max)) @(negedge clk);
    b        = tx_data;
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  // Keep tx_ready low for 50 cycles while a byte is pending.
  task automatic hold_tx();
    int n = 0;
    logic [7:0] d0;
    logic stable = 1'b1, saw_rx_ready = 1'b0, saw_err = 1'b0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    d0 = tx_data;
    repeat (50) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== d0) stable = 1'b0;
      if (rx_ready) saw_rx_ready = 1'b1;
      if (err) saw_err = 1'b1;
    end
    check("hold_tx_stable", stable, 1);
    check("hold_rx_ready", saw_rx_ready, 0);
    check("hold_no_timeout", saw_err, 0);
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] abyte, input int nw);
    logic [7:0] b;
    int a = int'(abyte[ADDR_W-1:0]);
    wr_log.delete();
    send_byte(cmd);
    send_byte(abyte);
    send_byte(8'(nw - 1));
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < BYTES; k++) send_byte(wdata[i][8*k +: 8]);
    recv_byte(b);
    check("wr_ack", b, 8'hA5);
    check("wr_count", wr_log.size(), nw);
    for (int i = 0; i < nw; i++) begin
      if (i < wr_log.size()) begin
        check("wr_addr", wr_log[i][DATA_W +: ADDR_W], (a + i) % WORDS);
        check("wr_data", wr_log[i][DATA_W-1:0], wdata[i]);
      end
      ref_mem[(a + i) % WORDS] = wdata[i];
    end
  endtask

  task automatic do_read(input logic [7:0] cmd, input logic [7:0] abyte, input int nw,
                         input int hold_at);
    logic [7:0] b;
    logic [DATA_W-1:0] w;
    int n = 0;
    int a = int'(abyte[ADDR_W-1:0]);
    send_byte(cmd);
    send_byte(abyte);
    send_byte(8'(nw - 1));
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 20);
    check("rd_latency", n, 3);
    for (int i = 0; i < nw; i++) begin
      w = ref_mem[(a + i) % WORDS];
      for (int k = 0; k < BYTES; k++) begin
        if (i * BYTES + k == hold_at) hold_tx();
        recv_byte(b);
        check("rd_byte", b, w[8*k +: 8]);
      end
    end
  endtask

  task automatic do_ping();
    logic [7:0] b;
    int e0 = err_pulses;
    send_byte(8'h80 | 8'($urandom_range(0, 63)));
    recv_byte(b);
    check("ping_rsp", b, 8'h5A);
    check("ping_no_err", err_pulses - e0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_csb_n"}, sram_csb_n, 1);
    check({tag, "_web_n"}, sram_web_n, 1);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_din"}, sram_din, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n, e0;
    logic saw;

    for (int i = 0; i < WORDS; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1 check("rx_ready_after_reset", rx_ready, 1);

    // Single word write then read-back.
    wdata[0] = 32'hDEADBEEF;
    do_write(8'h00, 8'h03, 1);
    do_read(8'h40, 8'h03, 1, -1);

    // Burst that wraps the address space.
    for (int i = 0; i < 3; i++) wdata[i] = $urandom;
    do_write(8'h00, 8'h0E, 3);
    do_read(8'h40, 8'h0E, 3, -1);

    do_ping();

    // Invalid opcode.
    e0 = err_pulses;
    send_byte(8'hC0);
    check("bad_err_now", err, 1);
    recv_byte(b);
    check("bad_rsp", b, 8'hEE);
    check("bad_err_pulses", err_pulses - e0, 1);
    @(negedge clk);
    check("bad_busy_after", busy, 0);

    // Timeout inside the first word: nothing committed, no reply.
    wr_log.delete();
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 40);
    check("tmo_cycles", n, TMO);
    @(negedge clk);
    check("tmo_err_one_cycle", err, 0);
    check("tmo_no_write", wr_log.size(), 0);
    check("tmo_busy", busy, 0);
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid) saw = 1'b1;
    end
    check("tmo_no_reply", saw, 0);

    // Timeout after one committed word: that word stays written.
    wr_log.delete();
    wdata[0] = $urandom;
    send_byte(8'h00);
    send_byte(8'h07);
    send_byte(8'h01);
    for (int k = 0; k < BYTES; k++) send_byte(wdata[0][8*k +: 8]);
    send_byte(8'h99);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 40);
    check("tmo2_cycles", n, TMO);
    check("tmo2_writes", wr_log.size(), 1);
    if (wr_log.size() > 0) check("tmo2_data", wr_log[0], {4'h7, wdata[0]});
    ref_mem[7] = wdata[0];
    do_read(8'h40, 8'h05, 4, -1);

    // Randomised command mix with gaps on both sides.
    rx_gap_max = 3;
    tx_gap_max = 3;
    for (int t = 0; t < 16; t++) begin
      int op = $urandom_range(0, 2);
      int a  = $urandom_range(0, WORDS - 1);
      int nw = $urandom_range(1, 4);
      logic [7:0] abyte = 8'(($urandom_range(0, 15) << 4) | a);
      if (op == 0) begin
        for (int i = 0; i < nw; i++) wdata[i] = $urandom;
        do_write(8'($urandom_range(0, 63)), abyte, nw);
      end else if (op == 1) begin
        do_read(8'h40 | 8'($urandom_range(0, 63)), abyte, nw, -1);
      end else begin
        do_ping();
      end
    end
    rx_gap_max = 0;
    tx_gap_max = 0;

    // Back-pressure on the transmitter in the middle of a burst read.
    do_read(8'h40, 8'h0E, 2, 5);

    // Reset while a read access is in flight.
    send_byte(8'h40);
    send_byte(8'h02);
    send_byte(8'h03);
    @(negedge clk);
    check("issue_csb_low", sram_csb_n, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("midreset");
    reset = 1'b0;
    @(posedge clk);
    #1 check("rx_ready_after_midreset", rx_ready, 1);
    do_read(8'h40, 8'h0E, 3, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
